// File: rtl/amp_gain_ctrl.sv
// Button-debounced five-level amplifier gain; AMP_GAIN_CTRL_RAMP_EN enables sample-paced gain ramping.
// Samples: fixed one-cycle latency and no back-pressure, so every smp_valid_i produces one smp_valid_o.
module amp_gain_ctrl #(
    parameter logic [15:0] DEB_CNT  = 16'd50000,
    parameter logic [7:0]  RAMP_SMP = 8'd32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic               smp_valid_i,
    input  logic signed [15:0] smp_i,
    output logic               smp_valid_o,
    output logic signed [31:0] smp_o,
    output logic [2:0]         gain_sel_o,
    output logic [4:0]         gain_o,
    output logic               busy_o
);

    // Bit 0 is the inc button, bit 1 the dec button.
    logic [1:0]  sync1_q, sync2_q, deb_q, deb_hit, press;
    logic [15:0] deb_cnt_q [2];
    logic [2:0]  sel_d, sel_q;
    logic [4:0]  target, gain_q;
    logic        smp_vld_q;
    logic signed [31:0] smp_q, smp_ext, gain_ext, prod;

    always_comb begin
        deb_hit = '0;
        press   = '0;
        for (int i = 0; i < 2; i++) begin
            deb_hit[i] = (sync2_q[i] != deb_q[i]) && (deb_cnt_q[i] == DEB_CNT - 16'd1);
            press[i]   = deb_hit[i] & sync2_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            sync1_q <= {btn_dec, btn_inc};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_hit[i]) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Simultaneous inc and dec presses cancel each other.
    always_comb begin
        sel_d = sel_q;
        if (press[0] && !press[1] && sel_q != 3'd4)
            sel_d = sel_q + 3'd1;
        else if (press[1] && !press[0] && sel_q != 3'd0)
            sel_d = sel_q - 3'd1;
    end

    always_comb begin
        case (sel_q)
            3'd0:    target = 5'd1;
            3'd1:    target = 5'd2;
            3'd2:    target = 5'd4;
            3'd3:    target = 5'd6;
            default: target = 5'd8;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_q <= '0;
        else     sel_q <= sel_d;
    end

`ifdef AMP_GAIN_CTRL_RAMP_EN
    typedef enum logic {IDLE, RAMP} state_t;
    state_t     state_q;
    logic [7:0] smp_cnt_q;
    logic [4:0] gain_step;

    assign gain_step = (target > gain_q) ? gain_q + 5'd1 : gain_q - 5'd1;

    // A target change mid-ramp just redirects gain_step; the sample count carries over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            smp_cnt_q <= '0;
            gain_q    <= 5'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    smp_cnt_q <= '0;
                    if (target != gain_q) state_q <= RAMP;
                end
                default: begin
                    if (target == gain_q) begin
                        state_q   <= IDLE;
                        smp_cnt_q <= '0;
                    end else if (smp_valid_i) begin
                        if (smp_cnt_q == RAMP_SMP - 8'd1) begin
                            smp_cnt_q <= '0;
                            gain_q    <= gain_step;
                            if (gain_step == target) state_q <= IDLE;
                        end else begin
                            smp_cnt_q <= smp_cnt_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy_o = (state_q == RAMP);
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) gain_q <= 5'd1;
        else     gain_q <= target;
    end

    assign busy_o = 1'b0;
`endif

    // The gain is at most 8, so the 32-bit product is always exact.
    assign smp_ext  = {{16{smp_i[15]}}, smp_i};
    assign gain_ext = {27'd0, gain_q};
    assign prod     = smp_ext * gain_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_vld_q <= 1'b0;
            smp_q     <= '0;
        end else begin
            smp_vld_q <= smp_valid_i;
            if (smp_valid_i) smp_q <= prod;
        end
    end

    assign smp_valid_o = smp_vld_q;
    assign smp_o       = smp_q;
    assign gain_sel_o  = sel_q;
    assign gain_o      = gain_q;

endmodule
